// File: rtl/data_sram_like_ram.sv
// rtl/data_sram_like_ram.sv - SRAM-like data port RAM with fixed response latency (optional stall: DATA_RAM_STALL_EN)
module data_sram_like_ram #(
  parameter int DEPTH_WORDS  = 4096,
  parameter int LATENCY      = 1,
  parameter int STALL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam int AW       = $clog2(DEPTH_WORDS);
  localparam int LAT_INIT = LATENCY - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  // Reject out-of-range parameters at elaboration.
  if (LATENCY < 1 || LATENCY > 4 || STALL_CYCLES < 0) begin : g_bad_param
    $error("data_sram_like_ram: LATENCY must be 1..4 and STALL_CYCLES >= 0");
  end

  // Address bits above the word index wrap around and are deliberately ignored.
  if (AW < 30) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^data_addr[31:2+AW];
  end

  logic [31:0]   mem [DEPTH_WORDS];
  logic [1:0]    state;
  logic [1:0]    lat_cnt;
  logic [31:0]   cap_q;
  logic [31:0]   hold_q;
  logic          cap_rd;
  logic [3:0]    byte_en;
  logic          misaligned;
  logic          accept;
  logic [AW-1:0] word_idx;

`ifdef DATA_RAM_STALL_EN
  localparam int STALL_INIT = (STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0;
  logic [15:0] stall_cnt;
`endif

  assign word_idx     = data_addr[2 +: AW];
  assign data_addr_ok = (state == S_IDLE);
  assign accept       = data_req & data_addr_ok;
  assign data_data_ok = (state == S_WAIT) && (lat_cnt == 2'd0);
  // The response word is visible only in the data_ok cycle of a read; otherwise the last read stays.
  assign data_rdata   = (data_data_ok && cap_rd) ? cap_q : hold_q;

  // Lane enables and alignment check from size and low address bits.
  always_comb begin
    byte_en    = 4'b1111;
    misaligned = 1'b0;
    case (data_size)
      2'd0: byte_en = 4'b0001 << data_addr[1:0];
      2'd1: begin
        byte_en    = data_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = data_addr[0];
      end
      default: misaligned = (data_addr[1:0] != 2'b00);
    endcase
  end

  // Writes commit on the acceptance edge; the array is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && accept && data_wr && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Transaction sequencing: accept, count down latency, respond, optionally stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lat_cnt <= 2'd0;
      cap_q   <= 32'd0;
      cap_rd  <= 1'b0;
      hold_q  <= 32'd0;
`ifdef DATA_RAM_STALL_EN
      stall_cnt <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_WAIT;
            lat_cnt <= LAT_INIT[1:0];
            cap_rd  <= ~data_wr;
            if (!data_wr) cap_q <= mem[word_idx];
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (cap_rd) hold_q <= cap_q;
`ifdef DATA_RAM_STALL_EN
            if (STALL_CYCLES > 0) begin
              state     <= S_STALL;
              stall_cnt <= STALL_INIT[15:0];
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_STALL: begin
`ifdef DATA_RAM_STALL_EN
          if (stall_cnt == 16'd0) state <= S_IDLE;
          else                    stall_cnt <= stall_cnt - 16'd1;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_like_ram.sv
// tb/tb_data_sram_like_ram.sv - self-checking bench for data_sram_like_ram (LATENCY 1 and 3 instances)
module tb_data_sram_like_ram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        wr    [2];
  logic [1:0]  sz    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        aok   [2];
  logic        dok   [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl     [2][4096];
  logic [31:0] last_rd [2];

  data_sram_like_ram #(.DEPTH_WORDS(4096), .LATENCY(1), .STALL_CYCLES(2)) u_lat1 (
    .clk(clk), .rst(rst), .data_req(req[0]), .data_wr(wr[0]), .data_size(sz[0]),
    .data_addr(addr[0]), .data_wdata(wd[0]), .data_rdata(rd[0]),
    .data_addr_ok(aok[0]), .data_data_ok(dok[0])
  );

  data_sram_like_ram #(.DEPTH_WORDS(4096), .LATENCY(3), .STALL_CYCLES(2)) u_lat3 (
    .clk(clk), .rst(rst), .data_req(req[1]), .data_wr(wr[1]), .data_size(sz[1]),
    .data_addr(addr[1]), .data_wdata(wd[1]), .data_rdata(rd[1]),
    .data_addr_ok(aok[1]), .data_data_ok(dok[1])
  );

  typedef struct {
    bit          w;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  // Reference write: a transfer of nb bytes at offset off is legal only when off is a multiple of nb.
  function automatic void mdl_write(input int d, input logic [1:0] s, input logic [31:0] a,
                                    input logic [31:0] w);
    int nb;
    int off;
    int ix;
    nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    off = int'(a % 32'd4);
    ix  = widx(a);
    if (off % nb != 0) return;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) mdl[d][ix][8*i +: 8] = w[8*i +: 8];
    end
  endfunction

  // One transaction; returns at #1 after the first edge where the port is free again.
  task automatic txn(input int d, input bit w, input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] wdv, input bit use_exp, input logic [31:0] exp_in,
                     input bit hold);
    int lat;
    int n;
    logic [31:0] exp_rd;
    lat = (d == 0) ? 1 : 3;
    n = 0;
    while (aok[d] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("addr_ok_idle", {31'd0, aok[d]}, 32'd1);
    if (w)            exp_rd = last_rd[d];
    else if (use_exp) exp_rd = exp_in;
    else              exp_rd = mdl[d][widx(a)];
    req[d] = 1'b1; wr[d] = w; sz[d] = s; addr[d] = a; wd[d] = wdv;
    @(posedge clk); #1;
    if (!hold) req[d] = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      chk("addr_ok_busy", {31'd0, aok[d]}, 32'd0);
      chk("data_ok_timing", {31'd0, dok[d]}, (c == lat) ? 32'd1 : 32'd0);
      if (c == lat) chk(w ? "rdata_on_write" : "rdata_read", rd[d], exp_rd);
      else begin @(posedge clk); #1; end
    end
    req[d] = 1'b0;
    if (w) mdl_write(d, s, a, wdv);
    else   last_rd[d] = exp_rd;
    @(posedge clk); #1;
`ifdef DATA_RAM_STALL_EN
    for (int k = 0; k < 2; k++) begin
      chk("addr_ok_stall", {31'd0, aok[d]}, 32'd0);
      @(posedge clk); #1;
    end
`endif
    chk("addr_ok_after", {31'd0, aok[d]}, 32'd1);
    chk("data_ok_after", {31'd0, dok[d]}, 32'd0);
    chk("rdata_held", rd[d], last_rd[d]);
  endtask

  // Accept a transaction on instance 1, then reset while it is still waiting.
  task automatic reset_in_wait(input bit w, input logic [31:0] a, input logic [31:0] wdv);
    req[1] = 1'b1; wr[1] = w; sz[1] = 2'd2; addr[1] = a; wd[1] = wdv;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("rst_pre_data_ok", {31'd0, dok[1]}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (w) mdl_write(1, 2'd2, a, wdv);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    chk("rst_addr_ok", {31'd0, aok[1]}, 32'd1);
    chk("rst_rdata", rd[1], 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_no_data_ok", {31'd0, dok[1]}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344, 32'h0};
    tbl[3]  = '{1'b1, 2'd0, 32'h0000_0021, 32'h0000_AA00, 32'h0};
    tbl[4]  = '{1'b1, 2'd1, 32'h0000_0022, 32'hBBCC_0000, 32'h0};
    tbl[5]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'hBBCC_AA44};
    tbl[6]  = '{1'b1, 2'd2, 32'h0000_0040, 32'h1122_3344, 32'h0};
    tbl[7]  = '{1'b1, 2'd1, 32'h0000_0041, 32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, 2'd2, 32'h0000_0040, 32'h0,         32'h1122_3344};
    tbl[9]  = '{1'b1, 2'd2, 32'h0000_4000, 32'h5A5A_5A5A, 32'h0};
    tbl[10] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'h5A5A_5A5A};
    tbl[11] = '{1'b0, 2'd0, 32'h0000_0103, 32'h0,         32'hDEAD_BEEF};
    tbl[12] = '{1'b1, 2'd3, 32'h0000_0102, 32'hFFFF_FFFF, 32'h0};
    tbl[13] = '{1'b0, 2'd1, 32'h0000_0102, 32'h0,         32'hDEAD_BEEF};

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; sz[d] = 2'd0; addr[d] = 32'd0; wd[d] = 32'd0;
      last_rd[d] = 32'd0;
      for (int i = 0; i < 4096; i++) mdl[d][i] = 32'd0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_addr_ok", {31'd0, aok[d]}, 32'd1);
      chk("reset_data_ok", {31'd0, dok[d]}, 32'd0);
      chk("reset_rdata", rd[d], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      txn(0, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].wdat, !tbl[i].w, tbl[i].exp, 1'b0);

    txn(1, 1'b1, 2'd2, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    txn(1, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1);

    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 8; p++)
        txn(d, 1'b1, 2'd2, p * 2048, $urandom, 1'b0, 32'h0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 40; t++) begin
        logic [31:0] ra;
        ra = ($urandom_range(0, 7) * 2048) + $urandom_range(0, 3) + ($urandom_range(0, 3) << 14);
        txn(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
            1'b0, 32'h0, 1'($urandom_range(0, 1)));
      end
    end

    reset_in_wait(1'b1, 32'h0000_0300, 32'h7700_0077);
    txn(1, 1'b0, 2'd2, 32'h0000_0300, 32'h0, 1'b1, 32'h7700_0077, 1'b0);
    reset_in_wait(1'b0, 32'h0000_0300, 32'h0);
    txn(0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_like_ram.md
DATA_SRAM_LIKE_RAM -- requirements
Module: data_sram_like_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, memory size in 32-bit words (power of two).
REQ-002 Parameter LATENCY, default 1, cycles from acceptance to response (legal 1..4).
REQ-003 Parameter STALL_CYCLES, default 2, extra addr_ok-low cycles after each response (used only with DATA_RAM_STALL_EN).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 data_req  in  1  master request valid.
REQ-007 data_wr  in  1  1=write, 0=read.
REQ-008 data_size  in  2  0=byte, 1=halfword, 2=word; 3 treated as word.
REQ-009 data_addr  in  32  byte address.
REQ-010 data_wdata  in  32  write data, already in byte-lane position.
REQ-011 data_rdata  out  32  read data, valid when data_data_ok=1.
REQ-012 data_addr_ok  out  1  request accepted this cycle when data_req=1.
REQ-013 data_data_ok  out  1  one-cycle response pulse.

Function
REQ-014 States IDLE, WAIT, STALL; data_addr_ok SHALL be 1 exactly when state=IDLE (combinational from state only).
REQ-015 Acceptance = data_req & data_addr_ok at a rising edge; IDLE->WAIT, latency counter loaded with LATENCY-1.
REQ-016 data_req while data_addr_ok=0 SHALL be ignored with no side effect; one request outstanding maximum.
REQ-017 Word index = data_addr[2 +: log2(DEPTH_WORDS)]; higher address bits ignored (wrap-around, no error).
REQ-018 Write SHALL commit to memory on the acceptance edge; byte enables: size 0 -> lane addr[1:0]; size 1 -> lanes {1,0} if addr[1]=0 else {3,2}; size 2/3 -> all lanes.
REQ-019 Misaligned write (size 1 with addr[0]=1, size 2/3 with addr[1:0]!=0) SHALL not modify memory but SHALL still complete with data_ok.
REQ-020 Read SHALL capture the full addressed word on the acceptance edge into a response register, regardless of size and alignment.
REQ-021 data_data_ok SHALL be 1 for exactly one cycle, the LATENCY-th cycle after the acceptance cycle (LATENCY=1: the next cycle); WAIT counter decrements once per cycle.
REQ-022 Read response: data_rdata = captured word during data_ok cycle and held until next read response; write response leaves data_rdata unchanged.
REQ-023 Read after write to same word in consecutive transactions SHALL return the written data.
REQ-024 After the data_ok cycle, state SHALL return to IDLE (or STALL when enabled); minimum request-to-request spacing LATENCY+1 cycles without stall.

Reset
REQ-025 rst=1 at an edge: state=IDLE, counters=0, data_data_ok=0, data_rdata=0; data_addr_ok=1 the cycle after reset.
REQ-026 Reset during WAIT/STALL SHALL discard the pending response (no data_ok); a write already committed remains.
REQ-027 Memory array SHALL NOT be cleared by reset; contents loadable by hierarchical testbench access.

Configuration
REQ-028 Macro DATA_RAM_STALL_EN: when defined, after each data_ok cycle state enters STALL for STALL_CYCLES cycles with data_addr_ok=0, then IDLE; STALL_CYCLES=0 goes directly to IDLE.
REQ-029 Without DATA_RAM_STALL_EN: STALL state unreachable, STALL_CYCLES ignored, IDLE re-entered immediately after data_ok.

Verification
REQ-030 LATENCY=1: write word 0xDEADBEEF @0x100, then read @0x100 -> data_ok one cycle after each acceptance, rdata=0xDEADBEEF.
REQ-031 Word 0x11223344 @0x20; byte write size0 addr 0x21 wdata 0x0000AA00; halfword write addr 0x22 wdata 0xBBCC0000 -> read @0x20 returns 0xBBCCAA44.
REQ-032 Misaligned halfword write addr 0x21 wdata 0xFFFFFFFF over 0x11223344 -> data_ok pulses, read returns 0x11223344.
REQ-033 LATENCY=3: read accepted cycle N -> data_ok only at N+3, data_addr_ok low N+1..N+3, data_req held high during wait causes no second acceptance until N+4.
REQ-034 DEPTH_WORDS=4096: write 0x5A5A5A5A @0x4000 then read @0x0 -> 0x5A5A5A5A (wrap).
REQ-035 Reset asserted in WAIT cycle before data_ok -> no data_ok, rdata=0, addr_ok=1 next cycle; with DATA_RAM_STALL_EN, STALL_CYCLES=2 -> addr_ok low 2 cycles after each data_ok.
